reg_file_32: RTL and testbench



---
 rtl/reg_file_32_pkg.sv | 28 ++
 rtl/reg_file_32_if.sv | 36 +++
 rtl/reg_file_32_read_port.sv | 43 ++++
 rtl/reg_file_32.sv | 71 +++++++
 tb/tb_reg_file_32.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_32_pkg.sv
// Shared datapath definitions for the register file and the ALU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the datapath widths, the named register indices and the ALU_Ctl
// opcode encoding. Keeping them together means the register file and the ALU
// always agree on operand width.
package reg_file_32_pkg;

    localparam int DP_WIDTH  = 32;
    localparam int DP_ADDR_W = 5;

    // Named architectural register indices
    localparam logic [DP_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [DP_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [DP_ADDR_W-1:0] REG_RA   = 5'd31;

    // ALU_Ctl opcodes driven by the ALU control unit
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctl_e;

endpackage

// File: rtl/reg_file_32_if.sv
// Register-file access bundle: one write port, two operand read ports, one debug read port.
// Latency: reads are combinational; writes land on the next rising clk edge.
// Backpressure: none; the register file accepts a write every cycle.
//
// master: datapath/control side (drives indices, write enable and data).
// slave : the register file (drives read data).
interface reg_file_32_if
    import reg_file_32_pkg::*;
#(
    parameter int WIDTH  = DP_WIDTH,
    parameter int ADDR_W = DP_ADDR_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic [ADDR_W-1:0] DbgReg;
    logic [WIDTH-1:0]  DbgData;

    modport master (
        output RegWrite, WriteReg, WriteData,
        output ReadReg1, ReadReg2, DbgReg,
        input  ReadData1, ReadData2, DbgData
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData,
        input  ReadReg1, ReadReg2, DbgReg,
        output ReadData1, ReadData2, DbgData
    );

endinterface

// File: rtl/reg_file_32_read_port.sv
// One combinational read port: zero-register override, write-through bypass, array mux.
// Latency: zero (purely combinational).
// Backpressure: none.
//
// Ports: regs (flattened storage), rd_idx (source index), byp_en (a write is
// live this cycle and reset is low), wr_idx/wr_data (the live write),
// rd_data (result).
module rf_read_port
    import reg_file_32_pkg::*;
#(
    parameter int WIDTH    = DP_WIDTH,
    parameter int ADDR_W   = DP_ADDR_W,
    parameter int ZERO_REG = 1
)
(
    input  logic [(2**ADDR_W)-1:0][WIDTH-1:0] regs,
    input  logic [ADDR_W-1:0]                 rd_idx,
    input  logic                              byp_en,
    input  logic [ADDR_W-1:0]                 wr_idx,
    input  logic [WIDTH-1:0]                  wr_data,
    output logic [WIDTH-1:0]                  rd_data
);

    logic idx_is_zero;
    logic idx_hits_wr;

    assign idx_is_zero = (ZERO_REG != 0) && (rd_idx == '0);
    // byp_en is checked first so an undriven write index cannot leak through
    // while no write is in flight.
    assign idx_hits_wr = byp_en && (wr_idx == rd_idx);

    // The zero-register check outranks the bypass: a dropped write to r0
    // must not be visible even in its own cycle.
    always_comb begin
        rd_data = regs[rd_idx];
        if (idx_is_zero) begin
            rd_data = '0;
        end else if (idx_hits_wr) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/reg_file_32.sv
// 32 x 32-bit general-purpose register file feeding ALU operands A and B.
// Latency: reads combinational with write-through bypass; write commits on the next clk edge.
// Backpressure: none; one write and two reads accepted every cycle.
//
// Ports: clk (datapath clock), reset (asynchronous, active-high, clears every
// register), bus (reg_file_32_if slave: RegWrite/WriteReg/WriteData write
// port, ReadReg1/ReadData1 to ALU A, ReadReg2/ReadData2 to ALU B or the
// ALU-source mux, DbgReg/DbgData committed-state debug view).
module reg_file_32
    import reg_file_32_pkg::*;
#(
    parameter int WIDTH    = DP_WIDTH,
    parameter int ADDR_W   = DP_ADDR_W,
    parameter int ZERO_REG = 1
)
(
    input  logic         clk,
    input  logic         reset,
    reg_file_32_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic                        wr_en;
    logic                        byp_en;

    // Writes to r0 are dropped when it is hardwired, so its storage stays 0.
    assign wr_en  = bus.RegWrite && !((ZERO_REG != 0) && (bus.WriteReg == '0));
    // A write asserted during reset is lost, so it must not be forwarded either.
    assign byp_en = bus.RegWrite && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_port1 (
        .regs    (regs),
        .rd_idx  (bus.ReadReg1),
        .byp_en  (byp_en),
        .wr_idx  (bus.WriteReg),
        .wr_data (bus.WriteData),
        .rd_data (bus.ReadData1)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_port2 (
        .regs    (regs),
        .rd_idx  (bus.ReadReg2),
        .byp_en  (byp_en),
        .wr_idx  (bus.WriteReg),
        .wr_data (bus.WriteData),
        .rd_data (bus.ReadData2)
    );

    // Debug view shows committed state only; the zero override is kept
    // explicit so it holds even if r0 storage were ever disturbed.
    assign bus.DbgData = ((ZERO_REG != 0) && (bus.DbgReg == '0)) ? '0 : regs[bus.DbgReg];

endmodule

// File: tb/tb_reg_file_32.sv
// Self-checking bench for reg_file_32: directed vectors with literal expectations
// plus a per-cycle comparison against an array-based reference model.
module tb_reg_file_32;
    import reg_file_32_pkg::*;

    logic clk;
    logic reset;

    int checks;
    int errors;

    reg_file_32_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    reg_file_32 #(
        .WIDTH    (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] model [32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (bus.RegWrite === 1'b1) begin
            if (bus.WriteReg != 5'd0) model[bus.WriteReg] = bus.WriteData;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (reset !== 1'b1 && bus.RegWrite === 1'b1) begin
            if (bus.WriteReg == idx) return bus.WriteData;
        end
        return model[idx];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        return model[idx];
    endfunction

    function automatic logic [31:0] alu(input alu_ctl_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_NOR: return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all three read outputs against the model
    always @(negedge clk) begin
        check("model_rd1", bus.ReadData1, exp_read(bus.ReadReg1));
        check("model_rd2", bus.ReadData2, exp_read(bus.ReadReg2));
        check("model_dbg", bus.DbgData,   exp_dbg(bus.DbgReg));
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] a_val;
        logic [31:0] b_val;

        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = 5'd0;
        bus.WriteData = 32'h0;
        bus.ReadReg1  = 5'd0;
        bus.ReadReg2  = 5'd0;
        bus.DbgReg    = 5'd0;

        // Power-on reset, asserted between clock edges
        #1 reset = 1'b1;
        #5;
        bus.ReadReg1 = REG_RA;
        bus.ReadReg2 = REG_SP;
        bus.DbgReg   = 5'd1;
        #1;
        check("reset_rd1", bus.ReadData1, 32'h0);
        check("reset_rd2", bus.ReadData2, 32'h0);
        check("reset_dbg", bus.DbgData,   32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fill r1..r31 with distinct patterns
        for (int i = 1; i < 32; i++) begin
            bus.RegWrite  = 1'b1;
            bus.WriteReg  = 5'(i);
            bus.WriteData = (32'(i) * 32'h01010101) ^ 32'hA5000000;
            step();
        end
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd17;
        #1;
        check("fill_r17", bus.ReadData1, 32'hB4111111);

        // Asynchronous reset pulse, then sweep every register before the next edge
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(i);
            bus.DbgReg   = 5'(i);
            #1;
            check("async_rst_rd1", bus.ReadData1, 32'h0);
            check("async_rst_rd2", bus.ReadData2, 32'h0);
            check("async_rst_dbg", bus.DbgData,   32'h0);
        end

        // Write / readback of r5
        step();
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd5;
        bus.WriteData = 32'hDEADBEEF;
        step();
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd5;
        bus.ReadReg2 = 5'd5;
        bus.DbgReg   = 5'd5;
        #1;
        check("r5_rd1", bus.ReadData1, 32'hDEADBEEF);
        check("r5_rd2", bus.ReadData2, 32'hDEADBEEF);
        check("r5_dbg", bus.DbgData,   32'hDEADBEEF);

        // Zero register: write dropped, never bypassed
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = REG_ZERO;
        bus.WriteData = 32'hFFFFFFFF;
        bus.ReadReg1  = REG_ZERO;
        bus.DbgReg    = REG_ZERO;
        #1;
        check("r0_same_rd1", bus.ReadData1, 32'h0);
        check("r0_same_dbg", bus.DbgData,   32'h0);
        check("r0_same_rd2", bus.ReadData2, 32'hDEADBEEF);
        step();
        bus.RegWrite = 1'b0;
        #1;
        check("r0_next_rd1", bus.ReadData1, 32'h0);
        check("r0_next_dbg", bus.DbgData,   32'h0);

        // Write-through bypass on both ports; debug port lags by one edge
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd7;
        bus.WriteData = 32'h00000011;
        step();
        bus.WriteData = 32'h00000022;
        bus.ReadReg1  = 5'd7;
        bus.ReadReg2  = 5'd7;
        bus.DbgReg    = 5'd7;
        #1;
        check("byp_rd1", bus.ReadData1, 32'h00000022);
        check("byp_rd2", bus.ReadData2, 32'h00000022);
        check("byp_dbg_old", bus.DbgData, 32'h00000011);
        step();
        bus.RegWrite = 1'b0;
        #1;
        check("byp_dbg_new", bus.DbgData,   32'h00000022);
        check("byp_rd1_new", bus.ReadData1, 32'h00000022);

        // Back-to-back writes to one index: last value wins
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd10;
        bus.WriteData = 32'h00000001;
        step();
        bus.WriteData = 32'h00000002;
        step();
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd10;
        bus.DbgReg   = 5'd10;
        #1;
        check("b2b_rd1", bus.ReadData1, 32'h00000002);
        check("b2b_dbg", bus.DbgData,   32'h00000002);

        // Highest indices, two different sources on the two ports
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = REG_SP;
        bus.WriteData = 32'h7FFFEFFC;
        step();
        bus.WriteReg  = REG_RA;
        bus.WriteData = 32'h00400020;
        step();
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = REG_SP;
        bus.ReadReg2 = REG_RA;
        #1;
        check("sp_rd1", bus.ReadData1, 32'h7FFFEFFC);
        check("ra_rd2", bus.ReadData2, 32'h00400020);

        // Unknown write index/data with RegWrite low must corrupt nothing
        bus.WriteReg  = 'x;
        bus.WriteData = 'x;
        bus.ReadReg1  = 5'd5;
        bus.ReadReg2  = 5'd7;
        bus.DbgReg    = REG_SP;
        #1;
        check("x_same_rd1", bus.ReadData1, 32'hDEADBEEF);
        step();
        step();
        check("x_rd1", bus.ReadData1, 32'hDEADBEEF);
        check("x_rd2", bus.ReadData2, 32'h00000022);
        check("x_dbg", bus.DbgData,   32'h7FFFEFFC);
        bus.WriteReg  = 5'd0;
        bus.WriteData = 32'h0;

        // ALU hookup: r1 = 10 (operand A), r2 = 3 (operand B)
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd1;
        bus.WriteData = 32'd10;
        step();
        bus.WriteReg  = 5'd2;
        bus.WriteData = 32'd3;
        step();
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd1;
        bus.ReadReg2 = 5'd2;
        #1;
        a_val = bus.ReadData1;
        b_val = bus.ReadData2;
        check("alu_opa", a_val, 32'd10);
        check("alu_opb", b_val, 32'd3);
        check("alu_sub", alu(ALU_SUB, a_val, b_val), 32'd7);
        check("alu_slt", alu(ALU_SLT, a_val, b_val), 32'd0);
        check("alu_add", alu(ALU_ADD, a_val, b_val), 32'd13);
        check("alu_add_zero", 32'(alu(ALU_ADD, a_val, b_val) == 32'd0), 32'd0);

        // Reset concurrent with a write: reset wins, write lost
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd3;
        bus.WriteData = 32'h12345678;
        step();
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd3;
        #1;
        check("pre_rst_r3", bus.ReadData1, 32'h12345678);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd4;
        bus.WriteData = 32'hAAAA5555;
        bus.ReadReg1  = 5'd4;
        bus.ReadReg2  = 5'd3;
        reset = 1'b1;
        #1;
        check("rst_no_byp_rd1", bus.ReadData1, 32'h0);
        check("rst_r3_rd2",     bus.ReadData2, 32'h0);
        step();
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        bus.DbgReg   = 5'd5;
        #1;
        check("post_rst_r4", bus.ReadData1, 32'h0);
        check("post_rst_r3", bus.ReadData2, 32'h0);
        check("post_rst_r5", bus.DbgData,   32'h0);

        // Writes work again after reset
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd4;
        bus.WriteData = 32'hAAAA5555;
        step();
        bus.RegWrite = 1'b0;
        bus.DbgReg   = 5'd4;
        #1;
        check("post_rst_wr_r4", bus.DbgData, 32'hAAAA5555);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
